// File: rtl/dm_arb_pkg_8085.sv
// dm_arb_pkg_8085: shared types, widths and burst-length clipping for the DM_8085 arbiter.
package dm_arb_pkg_8085;
  typedef enum logic {S_CPU, S_DMA} state_t;
  localparam int BEAT_W = 4;
  function automatic logic [BEAT_W-1:0] clip_len(input logic [BEAT_W-1:0] len, input logic [BEAT_W-1:0] max_len);
    return (len == '0) ? BEAT_W'(1) : ((len > max_len) ? max_len : len);
  endfunction
endpackage

// File: rtl/dm_burst_ctr_8085.sv
// dm_burst_ctr_8085: DMA burst base/beat/length registers and beat address generation.
module dm_burst_ctr_8085 import dm_arb_pkg_8085::*; #(
  parameter int AW = 8,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  input  logic [AW-1:0]     dma_addr,
  input  logic [BEAT_W-1:0] dma_len,
  output logic [AW-1:0]     beat_addr,
  output logic              last,
  output logic [BEAT_W-1:0] len_clip
);
  logic [AW-1:0]     base;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] len_q;
  assign len_clip  = clip_len(dma_len, BEAT_W'(BURST_MAX));
  assign beat_addr = base + AW'(beat);
  assign last      = (beat == len_q - BEAT_W'(1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base  <= '0;
      beat  <= '0;
      len_q <= '0;
    end else if (load) begin
      base  <= dma_addr;
      beat  <= '0;
      len_q <= len_clip;
    end else if (adv) begin
      beat <= beat + BEAT_W'(1);
    end
  end
endmodule

// File: rtl/dm_arbiter_8085.sv
// dm_arbiter_8085: CPU-priority arbiter for the DM_8085 port with starvation-protected DMA bursts.
module dm_arbiter_8085 import dm_arb_pkg_8085::*; #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [AW-1:0]     dma_addr,
  input  logic [BEAT_W-1:0] dma_len,
  input  logic [DW-1:0]     dma_wdata,
  output logic              dma_gnt,
  output logic [DW-1:0]     dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_done,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DW-1:0]     mem_rdata
);
  localparam logic [BEAT_W-1:0] STARVE = BEAT_W'(STARVE_MAX);
  state_t            state, state_n;
  logic [BEAT_W-1:0] wait_cnt, wait_n;
  logic              we_q;
  logic              cpu_acc, in_dma, accept, beat_go, last;
  logic [AW-1:0]     beat_addr;
  logic [BEAT_W-1:0] len_clip;
  assign cpu_acc = cpu_read | cpu_write;
  assign in_dma  = (state == S_DMA);
  assign accept  = !in_dma && dma_req && (!cpu_acc || wait_cnt == STARVE);
  assign beat_go = in_dma && dma_req;
  dm_burst_ctr_8085 #(.AW(AW), .BURST_MAX(BURST_MAX)) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .adv       (beat_go && !last),
    .dma_addr  (dma_addr),
    .dma_len   (dma_len),
    .beat_addr (beat_addr),
    .last      (last),
    .len_clip  (len_clip)
  );
  always_comb begin
    state_n = in_dma ? ((beat_go && !last) ? S_DMA : S_CPU) : (accept ? S_DMA : S_CPU);
    wait_n  = (in_dma || accept || !dma_req) ? '0 : ((wait_cnt == STARVE) ? wait_cnt : wait_cnt + BEAT_W'(1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CPU;
      wait_cnt   <= '0;
      we_q       <= 1'b0;
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_n;
      we_q       <= accept ? dma_we : we_q;
      dma_rdata  <= (beat_go && !we_q) ? mem_rdata : dma_rdata;
      dma_rvalid <= beat_go && !we_q;
      dma_done   <= beat_go && last;
    end
  end
  // An aborted burst (dma_req low in S_DMA) performs no access and returns to the CPU
  assign dma_gnt   = beat_go;
  assign mem_addr  = in_dma ? beat_addr : cpu_addr;
  assign mem_wdata = in_dma ? dma_wdata : cpu_wdata;
  assign mem_read  = rst_n && (in_dma ? (dma_gnt && !we_q) : cpu_read);
  assign mem_write = rst_n && (in_dma ? (dma_gnt && we_q) : cpu_write);
  assign cpu_rdata = in_dma ? '0 : mem_rdata;
  assign cpu_stall = in_dma && cpu_acc;
endmodule
